// File: rtl/seq_detector_param.sv
// Serial code-sequence detector with a loadable pattern.
// It compares a bit-serial stream against a PAT_LEN-bit pattern and
// raises a one-cycle gnt_0 pulse on each match.
// Options: overlapping or restarting match windows, a timeout that
// discards a partial sequence (abort pulse), and a saturating 8-bit
// match counter.
module seq_detector_param #(
    parameter int                 PAT_LEN         = 7,
    parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = 7'b1101011,
    parameter bit                 OVERLAP         = 1'b1,
    parameter int                 TIMEOUT         = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_0,
    input  logic               bit_valid,
    input  logic               pattern_load,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               cnt_clr,
    output logic               gnt_0,
    output logic               abort,
    output logic [7:0]         match_count
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] sr_q, sr_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic               gnt_q, gnt_d;
    logic               abort_q, abort_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [PAT_LEN-1:0] shifted_s;
    logic [FW-1:0]      fill_inc_s;
    logic               match_s;

    // Saturating increment: the counter sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'd255) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state logic. Priority: pattern load, then accepted bit, then idle timeout.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        idle_d     = idle_q;
        pat_d      = pat_q;
        gnt_d      = 1'b0;
        abort_d    = 1'b0;
        cnt_d      = cnt_q;
        match_s    = 1'b0;
        shifted_s  = {sr_q[PAT_LEN-2:0], req_0};
        fill_inc_s = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + 1'b1);

        if (pattern_load) begin
            // A coincident bit_valid is intentionally dropped.
            pat_d   = pattern_in;
            sr_d    = '0;
            fill_d  = '0;
            idle_d  = '0;
            state_d = EMPTY;
        end else if (bit_valid) begin
            sr_d    = shifted_s;
            fill_d  = fill_inc_s;
            idle_d  = '0;
            state_d = COLLECT;
            if ((fill_inc_s == FILL_FULL) && (shifted_s == pat_q)) begin
                match_s = 1'b1;
                gnt_d   = 1'b1;
                if (!OVERLAP) begin
                    // Restart the window so matches never share bits.
                    sr_d    = '0;
                    fill_d  = '0;
                    state_d = EMPTY;
                end else begin
                    // Keep the full window; the next bit may match again.
                    state_d = COLLECT;
                end
            end else begin
                match_s = 1'b0;
            end
        end else if ((TIMEOUT > 0) && (state_q == COLLECT)) begin
            if (idle_q == IDLE_LAST) begin
                sr_d    = '0;
                fill_d  = '0;
                idle_d  = '0;
                abort_d = 1'b1;
                state_d = EMPTY;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            // The idle timer only runs while a partial sequence is held.
            idle_d = (state_q == EMPTY) ? '0 : idle_q;
        end

        if (cnt_clr) begin
            cnt_d = 8'd0;
        end else if (match_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers. Reset is asynchronous and restores the default pattern.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            sr_q    <= '0;
            fill_q  <= '0;
            idle_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
            gnt_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            idle_q  <= idle_d;
            pat_q   <= pat_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_0       = gnt_q;
    assign abort       = abort_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param.
// It runs two instances side by side: index 0 uses OVERLAP=1 and
// index 1 uses OVERLAP=0, both with TIMEOUT=16.
// A queue-based reference model gives the expected outputs for every
// cycle. Directed tables and sequences add hand-computed expectations.
module tb_seq_detector_param;

    localparam logic [6:0] DEF_PAT = 7'b1101011;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_0 = 1'b0;
    logic       bit_valid = 1'b0;
    logic       pattern_load = 1'b0;
    logic [6:0] pattern_in = 7'd0;
    logic       cnt_clr = 1'b0;
    logic [1:0] gnt;
    logic [1:0] abrt;
    logic [7:0] cnt [2];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    bit         hist [2][$];
    int         idle [2];
    int         ec   [2];
    bit         eg   [2];
    bit         ea   [2];
    logic [6:0] m_pat = DEF_PAT;

    typedef struct {
        bit bv;
        bit b;
        bit e_gnt;
        bit e_abort;
        int e_cnt;
    } vec_t;
    vec_t tbl [9];

    seq_detector_param #(.PAT_LEN(7), .DEFAULT_PATTERN(7'b1101011), .OVERLAP(1'b1), .TIMEOUT(16)) u_ov (
        .clock(clock), .reset(reset), .req_0(req_0), .bit_valid(bit_valid),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .cnt_clr(cnt_clr),
        .gnt_0(gnt[0]), .abort(abrt[0]), .match_count(cnt[0])
    );

    seq_detector_param #(.PAT_LEN(7), .DEFAULT_PATTERN(7'b1101011), .OVERLAP(1'b0), .TIMEOUT(16)) u_no (
        .clock(clock), .reset(reset), .req_0(req_0), .bit_valid(bit_valid),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .cnt_clr(cnt_clr),
        .gnt_0(gnt[1]), .abort(abrt[1]), .match_count(cnt[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the matching rules: keep the
    // last 7 accepted bits and compare them with the pattern.
    task automatic model_step(input bit ld, input logic [6:0] pin, input bit bv,
                              input bit b, input bit clr);
        logic [6:0] v;
        bit g;
        bit a;
        for (int k = 0; k < 2; k++) begin
            g = 1'b0;
            a = 1'b0;
            if (ld) begin
                hist[k].delete();
                idle[k] = 0;
            end else if (bv) begin
                hist[k].push_back(b);
                if (hist[k].size() > 7) void'(hist[k].pop_front());
                idle[k] = 0;
                if (hist[k].size() == 7) begin
                    v = 7'd0;
                    for (int i = 0; i < 7; i++) v = {v[5:0], hist[k][i]};
                    g = (v == m_pat);
                end
                if (g && (k == 1)) hist[k].delete();
            end else if (hist[k].size() > 0) begin
                idle[k]++;
                if (idle[k] == 16) begin
                    hist[k].delete();
                    idle[k] = 0;
                    a = 1'b1;
                end
            end
            if (clr) ec[k] = 0;
            else if (g && ec[k] < 255) ec[k]++;
            eg[k] = g;
            ea[k] = a;
        end
        if (ld) m_pat = pin;
    endtask

    // Drive one cycle of inputs, then check both instances against the model.
    task automatic apply(input bit ld, input logic [6:0] pin, input bit bv,
                         input bit b, input bit clr);
        pattern_load = ld;
        pattern_in   = pin;
        bit_valid    = bv;
        req_0        = b;
        cnt_clr      = clr;
        @(posedge clock);
        #1;
        model_step(ld, pin, bv, b, clr);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_gnt%0d", k), gnt[k], eg[k]);
            chk($sformatf("model_abort%0d", k), abrt[k], ea[k]);
            chk($sformatf("model_cnt%0d", k), cnt[k], ec[k]);
        end
    endtask

    task automatic send_bit(input bit b, input bit clr);
        apply(1'b0, 7'd0, 1'b1, b, clr);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hist[k].delete();
            idle[k] = 0;
            ec[k]   = 0;
        end
        m_pat = DEF_PAT;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pattern_load = 1'b0;
        bit_valid    = 1'b0;
        cnt_clr      = 1'b0;
        #3;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_gnt%0d", k), gnt[k], 0);
            chk($sformatf("rst_abort%0d", k), abrt[k], 0);
            chk($sformatf("rst_cnt%0d", k), cnt[k], 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int aborts;
        int ptr;
        int pbv;
        bit ld;
        bit bv;
        bit b;
        bit clr;
        logic [6:0] pin;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};

        // Default pattern, table driven.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 7'd0, tbl[i].bv, tbl[i].b, 1'b0);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("tbl%0d_gnt%0d", i, k), gnt[k], tbl[i].e_gnt);
                chk($sformatf("tbl%0d_abort%0d", i, k), abrt[k], tbl[i].e_abort);
                chk($sformatf("tbl%0d_cnt%0d", i, k), cnt[k], tbl[i].e_cnt);
            end
        end

        // All-ones pattern followed by nine ones.
        do_reset();
        apply(1'b1, 7'b1111111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1, 1'b0);
            chk($sformatf("ones%0d_gnt_ov", i), gnt[0], (i >= 6) ? 1 : 0);
            chk($sformatf("ones%0d_gnt_no", i), gnt[1], (i == 6) ? 1 : 0);
        end
        chk("ones_cnt_ov", cnt[0], 3);
        chk("ones_cnt_no", cnt[1], 1);

        // Timeout discards a partial sequence.
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        aborts = 0;
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("to%0d_abort", i), abrt[0], (i == 15) ? 1 : 0);
            aborts += abrt[0];
        end
        chk("to_abort_once", aborts, 1);
        apply(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        chk("to_abort_clear", abrt[0], 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("to_partial_gnt", gnt[0], 0);
        for (int i = 0; i < 7; i++) send_bit(DEF_PAT[6-i], 1'b0);
        chk("to_full_gnt_ov", gnt[0], 1);
        chk("to_full_gnt_no", gnt[1], 1);

        // A pattern load together with bit_valid drops the bit and clears progress.
        do_reset();
        for (int i = 0; i < 4; i++) send_bit(DEF_PAT[6-i], 1'b0);
        apply(1'b1, 7'b0000001, 1'b1, DEF_PAT[2], 1'b0);
        chk("ld_gnt", gnt[0], 0);
        chk("ld_fill", int'(u_ov.fill_q), 0);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        chk("ld_pre_gnt", gnt[0], 0);
        send_bit(1'b1, 1'b0);
        chk("ld_gnt_ov", gnt[0], 1);
        chk("ld_gnt_no", gnt[1], 1);

        // Counter saturation, then a clear that coincides with a match.
        do_reset();
        for (int m = 0; m < 256; m++) begin
            for (int i = 0; i < 7; i++) send_bit(DEF_PAT[6-i], 1'b0);
        end
        chk("sat_cnt_ov", cnt[0], 255);
        chk("sat_cnt_no", cnt[1], 255);
        for (int i = 0; i < 6; i++) send_bit(DEF_PAT[6-i], 1'b0);
        send_bit(DEF_PAT[0], 1'b1);
        chk("clr_gnt_ov", gnt[0], 1);
        chk("clr_gnt_no", gnt[1], 1);
        chk("clr_cnt_ov", cnt[0], 0);
        chk("clr_cnt_no", cnt[1], 0);

        // Asynchronous reset clears a grant in progress.
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(DEF_PAT[6-i], 1'b0);
        chk("pre_rst_gnt", gnt[0], 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_gnt_ov", gnt[0], 0);
        chk("async_rst_gnt_no", gnt[1], 0);
        chk("async_rst_cnt", cnt[0], 0);
        do_reset();

        // Reset after six bits: the seventh bit alone must not match.
        for (int i = 0; i < 6; i++) send_bit(DEF_PAT[6-i], 1'b0);
        #2;
        do_reset();
        send_bit(DEF_PAT[0], 1'b0);
        chk("rst_mid_gnt_ov", gnt[0], 0);
        chk("rst_mid_gnt_no", gnt[1], 0);

        // Reset restores the default pattern.
        apply(1'b1, 7'b0000000, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(DEF_PAT[6-i], 1'b0);
        chk("rst_pat_gnt", gnt[0], 1);

        // Randomized traffic checked against the model.
        do_reset();
        ptr = 0;
        pbv = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pbv = 90;
                    1:       pbv = 50;
                    default: pbv = 4;
                endcase
            end
            ld  = ($urandom_range(0, 299) == 0);
            pin = ($urandom_range(0, 1) == 0) ? DEF_PAT : 7'($urandom);
            bv  = ($urandom_range(0, 99) < pbv);
            clr = ($urandom_range(0, 199) == 0);
            b   = ($urandom_range(0, 3) != 0) ? m_pat[6-ptr] : 1'($urandom);
            if (bv) ptr = (ptr + 1) % 7;
            apply(ld, pin, bv, b, clr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
